// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit CPU: opcode encodings, instruction field
// positions, the fetch-unit state type and small field-decoding helpers.
package cpu16_pkg;

  localparam int unsigned WORD_W = 16;

  localparam logic [3:0] OP_LOGIC = 4'b0000;
  localparam logic [3:0] OP_ARITH = 4'b0001;
  localparam logic [3:0] OP_SHIFT = 4'b0010;
  localparam logic [3:0] OP_JMP   = 4'b0011;
  localparam logic [3:0] OP_ADDI  = 4'b1001;
  localparam logic [3:0] OP_SUBI  = 4'b1010;
  localparam logic [3:0] OP_SLTI  = 4'b1011;
  localparam logic [3:0] OP_LW    = 4'b1100;
  localparam logic [3:0] OP_SW    = 4'b1101;
  localparam logic [3:0] OP_BEQ   = 4'b1111;

  localparam int unsigned OPC_MSB   = 15;
  localparam int unsigned OPC_LSB   = 12;
  localparam int unsigned IMM12_MSB = 11;
  localparam int unsigned IMM12_LSB = 0;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_REQ   = 2'd1,
    FS_HOLD  = 2'd2,
    FS_FLUSH = 2'd3
  } fetch_state_t;

  function automatic logic [3:0] opcode_of(input logic [WORD_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

  // Jumps stay inside the 4K-word page of the instruction after the jump.
  function automatic logic [WORD_W-1:0] jmp_target(input logic [WORD_W-1:0] pc_plus1,
                                                   input logic [WORD_W-1:0] instr);
    return {pc_plus1[WORD_W-1:OPC_LSB], instr[IMM12_MSB:IMM12_LSB]};
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, fetches over a req/ack memory port,
// resolves JMP locally and hands instructions to decode over valid/ready.
module instr_fetch
  import cpu16_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [15:0] if_instr,
  output logic [3:0]  if_opcode,
  output logic [15:0] if_pc,
  input  logic        redir_valid,
  input  logic [15:0] redir_pc,
  output logic [15:0] fetch_cnt
);

  fetch_state_t state_r, state_s;
  logic [15:0]  pc_r, pc_s;
  logic [15:0]  pending_r, pending_s;
  logic         req_r, req_s;
  logic [15:0]  addr_r, addr_s;
  logic         valid_r, valid_s;
  logic [15:0]  instr_r, instr_s;
  logic [15:0]  ifpc_r, ifpc_s;
  logic [15:0]  cnt_r, cnt_s;
  logic [15:0]  pc_plus1_s;

  assign pc_plus1_s = pc_r + 16'd1;

  // Next-state and next-output selection; all outputs come from the registers below.
  always_comb begin
    state_s   = state_r;
    pc_s      = pc_r;
    pending_s = pending_r;
    req_s     = req_r;
    addr_s    = addr_r;
    valid_s   = valid_r;
    instr_s   = instr_r;
    ifpc_s    = ifpc_r;
    cnt_s     = cnt_r;

    case (state_r)
      FS_IDLE: begin
        state_s = FS_REQ;
        req_s   = 1'b1;
        if (redir_valid) begin
          pc_s   = redir_pc;
          addr_s = redir_pc;
        end else begin
          addr_s = pc_r;
        end
      end

      FS_REQ: begin
        if (redir_valid) begin
          if (req_r && !imem_ack) begin
            // The outstanding read cannot be withdrawn; remember the target and drain it.
            pending_s = redir_pc;
            state_s   = FS_FLUSH;
          end else begin
            pc_s    = redir_pc;
            req_s   = 1'b1;
            addr_s  = redir_pc;
            state_s = FS_REQ;
          end
        end else if (!req_r) begin
          // Bubble cycle after a JMP: issue the request for the jump target.
          req_s  = 1'b1;
          addr_s = pc_r;
        end else if (imem_ack) begin
          req_s = 1'b0;
          if (opcode_of(imem_rdata) == OP_JMP) begin
            pc_s = jmp_target(pc_plus1_s, imem_rdata);
          end else begin
            instr_s = imem_rdata;
            ifpc_s  = pc_r;
            pc_s    = pc_plus1_s;
            valid_s = 1'b1;
            state_s = FS_HOLD;
          end
        end else begin
          state_s = FS_REQ;
        end
      end

      FS_HOLD: begin
        if (redir_valid) begin
          valid_s = 1'b0;
          pc_s    = redir_pc;
          req_s   = 1'b1;
          addr_s  = redir_pc;
          state_s = FS_REQ;
        end else if (if_ready) begin
          cnt_s   = cnt_r + 16'd1;
          valid_s = 1'b0;
          req_s   = 1'b1;
          addr_s  = pc_r;
          state_s = FS_REQ;
        end else begin
          state_s = FS_HOLD;
        end
      end

      FS_FLUSH: begin
        if (redir_valid) begin
          if (imem_ack) begin
            pc_s    = redir_pc;
            addr_s  = redir_pc;
            req_s   = 1'b1;
            state_s = FS_REQ;
          end else begin
            pending_s = redir_pc;
          end
        end else if (imem_ack) begin
          pc_s    = pending_r;
          addr_s  = pending_r;
          req_s   = 1'b1;
          state_s = FS_REQ;
        end else begin
          state_s = FS_FLUSH;
        end
      end

      default: begin
        state_s = FS_IDLE;
        req_s   = 1'b0;
        valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= FS_IDLE;
      pc_r      <= RESET_PC;
      pending_r <= RESET_PC;
      req_r     <= 1'b0;
      addr_r    <= RESET_PC;
      valid_r   <= 1'b0;
      instr_r   <= 16'h0000;
      ifpc_r    <= 16'h0000;
      cnt_r     <= 16'h0000;
    end else begin
      state_r   <= state_s;
      pc_r      <= pc_s;
      pending_r <= pending_s;
      req_r     <= req_s;
      addr_r    <= addr_s;
      valid_r   <= valid_s;
      instr_r   <= instr_s;
      ifpc_r    <= ifpc_s;
      cnt_r     <= cnt_s;
    end
  end

  assign imem_req  = req_r;
  assign imem_addr = addr_r;
  assign if_valid  = valid_r;
  assign if_instr  = instr_r;
  assign if_opcode = instr_r[OPC_MSB:OPC_LSB];
  assign if_pc     = ifpc_r;
  assign fetch_cnt = cnt_r;

endmodule
